rk8je_xfer_seq: RTL

RK8JE_XFER_SEQ -- requirements
Module: rk8je_xfer_seq

---
 rtl/rk8je_pkg.sv | 21 ++
 rtl/rk8je_xfer_seq_if.sv | 26 ++
 rtl/rk8je_wdog.sv | 28 ++
 rtl/rk8je_xfer_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rk8je_pkg.sv
// Shared definitions for the RK8-E data-break transfer sequencer.
package rk8je_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUFRD,
        ST_DMAREQ,
        ST_BUFWR,
        ST_FINISH
    } state_t;

    typedef logic [11:0] word_t;

    localparam logic [8:0] WC_HALF = 9'd128;
    localparam logic [8:0] WC_FULL = 9'd256;

    function automatic logic [8:0] blk_words(input logic half);
        return half ? WC_HALF : WC_FULL;
    endfunction

endpackage

// File: rtl/rk8je_xfer_seq_if.sv
// Sector-buffer port plus data-break (DMA) request/ack bus of the transfer sequencer.
interface rk8je_xfer_seq_if;
    import rk8je_pkg::*;

    logic [7:0]  bufaddr;
    word_t       bufwdata;
    logic        bufwena;
    word_t       bufrdata;
    logic        dmareq;
    logic        dmawrite;
    logic [14:0] dmaaddr;
    word_t       dmawdata;
    logic        dmaack;
    word_t       dmardata;

    modport master (
        output bufaddr, bufwdata, bufwena, dmareq, dmawrite, dmaaddr, dmawdata,
        input  bufrdata, dmaack, dmardata
    );

    modport slave (
        input  bufaddr, bufwdata, bufwena, dmareq, dmawrite, dmaaddr, dmawdata,
        output bufrdata, dmaack, dmardata
    );

endinterface

// File: rtl/rk8je_wdog.sv
// Data-break watchdog: counts cycles while restart is low, expire on the TIMEOUT-th cycle.
// Combinational expire, one register stage; saturates until restarted.
module rk8je_wdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic restart,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = !restart && (cnt == LAST);

endmodule

// File: rtl/rk8je_xfer_seq.sv
// RK8-E sector transfer sequencer: moves 128/256 words between disk buffer and memory via data break.
// One word per BUFRD+DMAREQ (write) or DMAREQ+BUFWR (read); DMAREQ holds until dmaack or watchdog expiry.
module rk8je_xfer_seq
    import rk8je_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     wrmem,
    input  logic                     halfblk,
    input  logic [2:0]               memfld,
    input  logic [11:0]              memaddr_in,
    output logic                     busy,
    output logic                     done,
    output logic                     timerr,
    output logic [11:0]              memaddr_out,
    output logic [8:0]               wordcnt,
    rk8je_xfer_seq_if.master         bus
);
    state_t      state, state_nx;
    logic [2:0]  fld_q;
    word_t       addr_q;
    logic [8:0]  cnt_q;
    logic [7:0]  ba_q;
    logic        wr_q;
    word_t       wdata_q;
    word_t       bwdata_q;
    logic        rd_pend;
    logic        timerr_q;
    logic        expire;
    logic        load, step, cap_rd, set_terr, last;

    // Watchdog runs only while requesting; every DMAREQ entry starts from zero.
    rk8je_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .restart (state != ST_DMAREQ),
        .expire  (expire)
    );

    assign last = (cnt_q == 9'd1);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        cap_rd   = 1'b0;
        set_terr = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    load     = 1'b1;
                    state_nx = wrmem ? ST_BUFRD : ST_DMAREQ;
                end
                ST_BUFRD: state_nx = ST_DMAREQ;
                ST_DMAREQ: begin
                    // An ack in the expiry cycle still completes the word.
                    if (bus.dmaack) begin
                        if (wr_q) begin
                            step     = 1'b1;
                            state_nx = last ? ST_FINISH : ST_BUFRD;
                        end else begin
                            cap_rd   = 1'b1;
                            state_nx = ST_BUFWR;
                        end
                    end else if (expire) begin
                        set_terr = 1'b1;
                        state_nx = ST_FINISH;
                    end
                end
                ST_BUFWR: begin
                    step     = 1'b1;
                    state_nx = last ? ST_FINISH : ST_DMAREQ;
                end
                ST_FINISH: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fld_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ba_q     <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            bwdata_q <= '0;
            rd_pend  <= 1'b0;
            timerr_q <= 1'b0;
        end else begin
            rd_pend <= (state == ST_BUFRD) && !abort;
            if (load) begin
                fld_q    <= memfld;
                addr_q   <= memaddr_in;
                wr_q     <= wrmem;
                cnt_q    <= blk_words(halfblk);
                ba_q     <= '0;
                timerr_q <= 1'b0;
            end
            if (step) begin
                addr_q <= addr_q + 12'd1;
                ba_q   <= ba_q + 8'd1;
                cnt_q  <= cnt_q - 9'd1;
            end
            if (rd_pend)  wdata_q  <= bus.bufrdata;
            if (cap_rd)   bwdata_q <= bus.dmardata;
            if (set_terr) timerr_q <= 1'b1;
        end
    end

    // Buffer data arrives in the first DMAREQ cycle; bypass it until the capture register holds it.
    assign bus.dmawdata = rd_pend ? bus.bufrdata : wdata_q;
    assign bus.dmareq   = (state == ST_DMAREQ);
    assign bus.dmawrite = (state == ST_DMAREQ) && wr_q;
    assign bus.dmaaddr  = {fld_q, addr_q};
    assign bus.bufaddr  = ba_q;
    assign bus.bufwdata = bwdata_q;
    assign bus.bufwena  = (state == ST_BUFWR);

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_FINISH);
    assign timerr      = timerr_q;
    assign memaddr_out = addr_q;
    assign wordcnt     = cnt_q;

endmodule
